// File: rtl/fsk2_zc_demod_if.sv
// Sample/word link of the 2FSK zero-crossing demodulator.
// master: sample source and word consumer; slave: the demodulator.
interface fsk2_zc_demod_if;
  logic signed [15:0] rx_in;
  logic        [15:0] data_out;
  logic               data_valid;
  logic               frame_err;
  logic               carrier_ok;
  logic               busy;

  modport master (
    output rx_in,
    input  data_out, data_valid, frame_err, carrier_ok, busy
  );

  modport slave (
    input  rx_in,
    output data_out, data_valid, frame_err, carrier_ok, busy
  );
endinterface

// File: rtl/fsk2_zc_demod.sv
// 2FSK demodulator: hysteretic zero-crossing tone classifier feeding a
// UART-style (start, 16 data MSB first, stop) bit recovery FSM.
module fsk2_zc_demod #(
  parameter int unsigned SPB         = 200,
  parameter int unsigned HALF_THRESH = 12,
  parameter int unsigned HYST        = 64,
  parameter int unsigned TIMEOUT     = 64
) (
  input logic            sys_clk,
  input logic            sys_rst_n,
  fsk2_zc_demod_if.slave link
);

  localparam int unsigned PW = (SPB > 1) ? $clog2(SPB) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic signed [15:0] HYST_POS = HYST[15:0];
  localparam logic signed [15:0] HYST_NEG = -HYST_POS;
  localparam logic [PW-1:0] HALF_M1 = PW'(SPB / 2 - 1);
  localparam logic [PW-1:0] BIT_M1  = PW'(SPB - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic signed [15:0] rx_q;
  logic               pos;
  logic [CW-1:0]      hcount;
  logic               tone;
  logic               carrier;
  logic               above;
  logic               below;
  logic               crossing;

  state_t             state;
  logic [PW-1:0]      phase;
  logic [4:0]         bitcnt;
  logic [15:0]        shreg;

  assign above    = (rx_q > HYST_POS);
  assign below    = (rx_q < HYST_NEG);
  assign crossing = (above && !pos) || (below && pos);

  // Tone is decided on the interval ending at each crossing; the counter
  // then restarts at 1 so that interval == cycles between crossings.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rx_q    <= '0;
      pos     <= 1'b1;
      hcount  <= '0;
      tone    <= 1'b1;
      carrier <= 1'b0;
    end else begin
      rx_q <= link.rx_in;
      if (above) begin
        pos <= 1'b1;
      end else if (below) begin
        pos <= 1'b0;
      end
      if (crossing) begin
        tone    <= (hcount < CW'(HALF_THRESH));
        carrier <= 1'b1;
        hcount  <= CW'(1);
      end else if (hcount == CW'(TIMEOUT)) begin
        carrier <= 1'b0;
        tone    <= 1'b1;
      end else begin
        hcount <= hcount + 1'b1;
      end
    end
  end

  assign link.carrier_ok = carrier;

  // Carrier loss is checked ahead of the per-state logic so it beats a
  // coincident stop-bit decision.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state           <= S_IDLE;
      phase           <= '0;
      bitcnt          <= '0;
      shreg           <= '0;
      link.data_out   <= '0;
      link.data_valid <= 1'b0;
      link.frame_err  <= 1'b0;
      link.busy       <= 1'b0;
    end else begin
      link.data_valid <= 1'b0;
      link.frame_err  <= 1'b0;
      if (state != S_IDLE && !carrier) begin
        state          <= S_IDLE;
        link.busy      <= 1'b0;
        link.frame_err <= (state != S_START);
      end else begin
        case (state)
          S_IDLE: begin
            if (carrier && !tone) begin
              state     <= S_START;
              phase     <= '0;
              link.busy <= 1'b1;
            end
          end
          S_START: begin
            if (phase == HALF_M1) begin
              phase <= '0;
              if (!tone) begin
                state  <= S_DATA;
                bitcnt <= '0;
              end else begin
                state     <= S_IDLE;
                link.busy <= 1'b0;
              end
            end else begin
              phase <= phase + 1'b1;
            end
          end
          S_DATA: begin
            if (phase == BIT_M1) begin
              shreg  <= {shreg[14:0], tone};
              phase  <= '0;
              bitcnt <= bitcnt + 1'b1;
              if (bitcnt == 5'd15) begin
                state <= S_STOP;
              end
            end else begin
              phase <= phase + 1'b1;
            end
          end
          S_STOP: begin
            if (phase == BIT_M1) begin
              if (tone) begin
                link.data_out   <= shreg;
                link.data_valid <= 1'b1;
              end else begin
                link.frame_err <= 1'b1;
              end
              state     <= S_IDLE;
              phase     <= '0;
              link.busy <= 1'b0;
            end else begin
              phase <= phase + 1'b1;
            end
          end
          default: begin
            state     <= S_IDLE;
            link.busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fsk2_zc_demod.sv
// Directed bench for fsk2_zc_demod: square-wave FSK frames, glitches,
// carrier dropouts and reset aborts with hand-derived cycle expectations.
module tb_fsk2_zc_demod;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;

  fsk2_zc_demod_if bus_if ();

  fsk2_zc_demod #(
    .SPB        (200),
    .HALF_THRESH(12),
    .HYST       (64),
    .TIMEOUT    (64)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .link     (bus_if)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic lvl = 1'b1;
  int unsigned blank_bit = 99;
  logic noise_mode = 1'b0;
  int frame_start = 0;

  int n_valid, n_ferr, n_both, n_long, busy_ticks;
  int busy_rise, carrier_fall, ferr_cyc;
  logic busy_at_ferr;
  int vcyc[8];
  logic [15:0] vword[8];
  logic prev_valid = 1'b0, prev_ferr = 1'b0, prev_busy = 1'b0, prev_carrier = 1'b0;

  task automatic clr();
    n_valid = 0; n_ferr = 0; n_both = 0; n_long = 0; busy_ticks = 0;
    busy_rise = -1; carrier_fall = -1; ferr_cyc = -1; busy_at_ferr = 1'bx;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic signed [15:0] s);
    bus_if.rx_in = s;
    @(posedge sys_clk);
    #1;
    cyc++;
    if (bus_if.data_valid === 1'b1) begin
      if (n_valid < 8) begin
        vcyc[n_valid] = cyc;
        vword[n_valid] = bus_if.data_out;
      end
      n_valid++;
      if (prev_valid) n_long++;
    end
    if (bus_if.frame_err === 1'b1) begin
      n_ferr++;
      ferr_cyc = cyc;
      busy_at_ferr = bus_if.busy;
      if (prev_ferr) n_long++;
    end
    if (bus_if.data_valid === 1'b1 && bus_if.frame_err === 1'b1) n_both++;
    if (bus_if.busy === 1'b1) begin
      busy_ticks++;
      if (!prev_busy) busy_rise = cyc;
    end
    if (prev_carrier && bus_if.carrier_ok === 1'b0) carrier_fall = cyc;
    prev_valid = bus_if.data_valid;
    prev_ferr = bus_if.frame_err;
    prev_busy = bus_if.busy;
    prev_carrier = bus_if.carrier_ok;
  endtask

  task automatic send_tone(input int unsigned len, input int unsigned h);
    for (int unsigned c = 0; c < len; c++) begin
      if (c % h == 0) lvl = ~lvl;
      tick(lvl ? 16'sd1000 : -16'sd1000);
    end
  endtask

  task automatic send_blank(input int unsigned len);
    for (int unsigned c = 0; c < len; c++) begin
      if (noise_mode) tick((c % 2 == 1) ? 16'sd50 : -16'sd50);
      else tick(16'sd0);
    end
  endtask

  task automatic send_frame(input logic [15:0] w, input logic stop, input int unsigned nbits);
    logic b;
    frame_start = cyc + 1;
    for (int unsigned i = 0; i < nbits; i++) begin
      if (i == 0) b = 1'b0;
      else if (i <= 16) b = w[16-i];
      else b = stop;
      if (i == blank_bit) send_blank(200);
      else send_tone(200, b ? 8 : 16);
    end
  endtask

  initial begin
    int fs;
    bus_if.rx_in = '0;
    clr();

    // reset state
    sys_rst_n = 1'b0;
    tick(0); tick(0); tick(0);
    check("rst_data_out", bus_if.data_out, 0);
    check("rst_data_valid", bus_if.data_valid, 0);
    check("rst_frame_err", bus_if.frame_err, 0);
    check("rst_carrier_ok", bus_if.carrier_ok, 0);
    check("rst_busy", bus_if.busy, 0);
    sys_rst_n = 1'b1;

    // clean frame 0xA5C3 after idle mark
    clr();
    send_tone(500, 8);
    send_frame(16'hA5C3, 1'b1, 18);
    fs = frame_start;
    send_tone(300, 8);
    check("f1_valid_count", n_valid, 1);
    check("f1_data_out", bus_if.data_out, 16'hA5C3);
    check("f1_frame_err_count", n_ferr, 0);
    check("f1_busy_rise", busy_rise, fs + 18);
    check("f1_valid_cycle", vcyc[0], fs + 3518);
    check("f1_busy_after", bus_if.busy, 0);

    // 60-cycle space burst: START for SPB/2 cycles, then rejected
    clr();
    send_tone(60, 16);
    send_tone(400, 8);
    check("glitch_busy_ticks", busy_ticks, 100);
    check("glitch_valid_count", n_valid, 0);
    check("glitch_ferr_count", n_ferr, 0);

    // good 0x1234 then 0xFFFF with space stop bit
    clr();
    send_frame(16'h1234, 1'b1, 18);
    send_tone(100, 8);
    send_frame(16'hFFFF, 1'b0, 18);
    send_tone(300, 8);
    check("badstop_valid_count", n_valid, 1);
    check("badstop_valid_word", vword[0], 16'h1234);
    check("badstop_ferr_count", n_ferr, 1);
    check("badstop_data_out", bus_if.data_out, 16'h1234);

    // rx_in held at 0 through data bit 7
    clr();
    blank_bit = 8; noise_mode = 1'b0;
    send_frame(16'hA5C3, 1'b1, 9);
    fs = frame_start;
    blank_bit = 99;
    send_tone(400, 8);
    check("zero_carrier_fall", carrier_fall, fs + 1657);
    check("zero_ferr_cycle", ferr_cyc, fs + 1658);
    check("zero_ferr_count", n_ferr, 1);
    check("zero_busy_at_ferr", busy_at_ferr, 0);
    check("zero_valid_count", n_valid, 0);

    // +/-50 noise inside hysteresis through data bit 7
    clr();
    blank_bit = 8; noise_mode = 1'b1;
    send_frame(16'h3C5A, 1'b1, 9);
    fs = frame_start;
    blank_bit = 99; noise_mode = 1'b0;
    send_tone(400, 8);
    check("noise_carrier_fall", carrier_fall, fs + 1657);
    check("noise_ferr_cycle", ferr_cyc, fs + 1658);
    check("noise_ferr_count", n_ferr, 1);
    check("noise_busy_at_ferr", busy_at_ferr, 0);

    // one-cycle reset in the middle of data, then clean 0x8001
    clr();
    send_frame(16'hA5C3, 1'b1, 5);
    sys_rst_n = 1'b0;
    tick(0);
    sys_rst_n = 1'b1;
    check("midrst_data_out", bus_if.data_out, 0);
    check("midrst_busy", bus_if.busy, 0);
    check("midrst_carrier_ok", bus_if.carrier_ok, 0);
    send_tone(400, 8);
    check("midrst_no_pulses", n_valid + n_ferr, 0);
    send_frame(16'h8001, 1'b1, 18);
    send_tone(300, 8);
    check("midrst_valid_count", n_valid, 1);
    check("midrst_data_out_8001", bus_if.data_out, 16'h8001);
    check("midrst_ferr_count", n_ferr, 0);

    // three frames back to back
    clr();
    send_frame(16'h0000, 1'b1, 18);
    fs = frame_start;
    send_frame(16'hFFFF, 1'b1, 18);
    send_frame(16'h5AA5, 1'b1, 18);
    send_tone(300, 8);
    check("b2b_valid_count", n_valid, 3);
    check("b2b_first_cycle", vcyc[0], fs + 3518);
    check("b2b_gap01", vcyc[1] - vcyc[0], 3600);
    check("b2b_gap12", vcyc[2] - vcyc[1], 3600);
    check("b2b_word0", vword[0], 16'h0000);
    check("b2b_word1", vword[1], 16'hFFFF);
    check("b2b_word2", vword[2], 16'h5AA5);
    check("b2b_ferr_count", n_ferr, 0);
    check("pulse_overlap_or_long", n_both + n_long, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
